// File: rtl/otter_bp_pkg.sv
// Shared types and helpers for the OTTER branch predictor.
// Entry fields are sized for the widest supported configuration (XLEN <= 64,
// CTR_W <= 4); unused upper bits stay zero and are trimmed by synthesis.
package otter_bp_pkg;

  localparam int unsigned MaxXlen = 64;
  localparam int unsigned MaxCtrW = 4;

  typedef logic [MaxXlen-1:0] bp_word_t;
  typedef logic [MaxCtrW-1:0] bp_ctr_t;

  typedef struct packed {
    logic     valid;
    bp_word_t tag;
    bp_word_t target;
    bp_ctr_t  counter;
  } bp_entry_t;

  // Table index: pc[idx_w+1:2], returned zero-extended.
  function automatic bp_word_t bp_index(bp_word_t pc, int unsigned idx_w);
    return (pc >> 2) & ((bp_word_t'(1) << idx_w) - bp_word_t'(1));
  endfunction

  // Tag: pc[XLEN-1:idx_w+2]; upper bits are zero because pc arrives zero-extended.
  function automatic bp_word_t bp_tag(bp_word_t pc, int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

  function automatic bp_ctr_t ctr_max(int unsigned w);
    return bp_ctr_t'((32'd1 << w) - 32'd1);
  endfunction

  // Weakly not-taken: just below the MSB threshold.
  function automatic bp_ctr_t ctr_reset(int unsigned w);
    return bp_ctr_t'((32'd1 << (w - 1)) - 32'd1);
  endfunction

  // Weakly taken: MSB set, all lower bits clear.
  function automatic bp_ctr_t ctr_weak_taken(int unsigned w);
    return bp_ctr_t'(32'd1 << (w - 1));
  endfunction

  // Saturating next value; load beats set_max beats inc/dec, inc&dec holds.
  function automatic bp_word_t sat_next(bp_word_t cur, bp_word_t max, logic inc, logic dec,
                                        logic set_max, logic load, bp_word_t load_val);
    if (load) return load_val;
    if (set_max) return max;
    if (inc && !dec) return (cur == max) ? cur : cur + bp_word_t'(1);
    if (dec && !inc) return (cur == '0) ? cur : cur - bp_word_t'(1);
    return cur;
  endfunction

endpackage

// File: rtl/otter_branch_predictor_if.sv
// Fetch lookup, Execute feedback and performance-counter bundle.
interface otter_branch_predictor_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PERF_W = 32
);
  logic [XLEN-1:0]   pcf_i;
  logic              pred_hit_o;
  logic              pred_taken_o;
  logic [XLEN-1:0]   pred_target_o;
  logic              upd_valid_i;
  logic [XLEN-1:0]   upd_pc_i;
  logic              upd_is_jump_i;
  logic              upd_taken_i;
  logic [XLEN-1:0]   upd_target_i;
  logic              upd_pred_taken_i;
  logic [XLEN-1:0]   upd_pred_target_i;
  logic              mispredict_o;
  logic [XLEN-1:0]   redirect_pc_o;
  logic [PERF_W-1:0] branch_cnt_o;
  logic [PERF_W-1:0] mispred_cnt_o;

  modport slave (
    input  pcf_i, upd_valid_i, upd_pc_i, upd_is_jump_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i,
    output pred_hit_o, pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
           branch_cnt_o, mispred_cnt_o
  );

  modport master (
    output pcf_i, upd_valid_i, upd_pc_i, upd_is_jump_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_target_i,
    input  pred_hit_o, pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
           branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/otter_sat_counter.sv
// Saturating up/down counter with synchronous active-high reset (W <= 64).
module otter_sat_counter
  import otter_bp_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         set_max,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);
  localparam bp_word_t Max = bp_word_t'({W{1'b1}});

  logic [W-1:0] cnt_q, cnt_d;

  // Next count, saturating at both ends
  always_comb begin
    cnt_d = W'(sat_next(bp_word_t'(cnt_q), Max, inc, dec, set_max, load,
                        bp_word_t'(load_val)));
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/otter_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters for the OTTER pipeline.
// Lookup reads the registered table (no bypass of a same-cycle update).
module otter_branch_predictor
  import otter_bp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned PERF_W  = 32
) (
  input logic                    CLK,
  input logic                    RESET,
  otter_branch_predictor_if.slave bp
);
  localparam int unsigned IdxW         = $clog2(ENTRIES);
  localparam bp_ctr_t     CtrMax       = ctr_max(CTR_W);
  localparam bp_ctr_t     CtrReset     = ctr_reset(CTR_W);
  localparam bp_ctr_t     CtrWeakTaken = ctr_weak_taken(CTR_W);

  bp_entry_t       table_q [ENTRIES];
  bp_entry_t       entry_d;
  logic            wr_en;
  logic [IdxW-1:0] lk_idx, up_idx;
  bp_word_t        lk_tag, up_tag;
  logic            lk_hit, lk_taken, up_hit;
  logic            mispredict;
  logic [XLEN-1:0] upc_plus4;

  // Fetch lookup; forced to a miss while RESET is asserted
  always_comb begin
    lk_idx   = IdxW'(bp_index(bp_word_t'(bp.pcf_i), IdxW));
    lk_tag   = bp_tag(bp_word_t'(bp.pcf_i), IdxW);
    lk_hit   = !RESET && table_q[lk_idx].valid && (table_q[lk_idx].tag == lk_tag);
    lk_taken = lk_hit && table_q[lk_idx].counter[CTR_W-1];
    bp.pred_hit_o    = lk_hit;
    bp.pred_taken_o  = lk_taken;
    bp.pred_target_o = lk_taken ? table_q[lk_idx].target[XLEN-1:0] : bp.pcf_i + XLEN'(4);
  end

  // Mispredict detection and redirect target
  always_comb begin
    upc_plus4  = bp.upd_pc_i + XLEN'(4);
    mispredict = bp.upd_valid_i &&
                 ((bp.upd_taken_i != bp.upd_pred_taken_i) ||
                  (bp.upd_taken_i && (bp.upd_target_i != bp.upd_pred_target_i)));
    bp.mispredict_o  = mispredict;
    bp.redirect_pc_o = (mispredict && bp.upd_taken_i) ? bp.upd_target_i : upc_plus4;
  end

  // Training: compute the replacement entry for the resolved instruction
  always_comb begin
    up_idx  = IdxW'(bp_index(bp_word_t'(bp.upd_pc_i), IdxW));
    up_tag  = bp_tag(bp_word_t'(bp.upd_pc_i), IdxW);
    up_hit  = table_q[up_idx].valid && (table_q[up_idx].tag == up_tag);
    entry_d = table_q[up_idx];
    wr_en   = 1'b0;
    if (bp.upd_valid_i) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (bp.upd_taken_i) begin
          entry_d.target  = bp_word_t'(bp.upd_target_i);
          entry_d.counter = bp.upd_is_jump_i ? CtrMax :
              bp_ctr_t'(sat_next(bp_word_t'(entry_d.counter), bp_word_t'(CtrMax),
                                 1'b1, 1'b0, 1'b0, 1'b0, '0));
        end else begin
          entry_d.counter = bp_ctr_t'(sat_next(bp_word_t'(entry_d.counter),
                                               bp_word_t'(CtrMax), 1'b0, 1'b1, 1'b0, 1'b0,
                                               '0));
        end
      end else if (bp.upd_taken_i) begin
        // Miss or alias: allocate over whatever lives at this index
        wr_en           = 1'b1;
        entry_d.valid   = 1'b1;
        entry_d.tag     = up_tag;
        entry_d.target  = bp_word_t'(bp.upd_target_i);
        entry_d.counter = bp.upd_is_jump_i ? CtrMax : CtrWeakTaken;
      end
    end
  end

  // Table storage; reset discards any same-cycle update
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, counter: CtrReset};
      end
    end else if (wr_en) begin
      table_q[up_idx] <= entry_d;
    end
  end

  otter_sat_counter #(.W(PERF_W)) u_branch_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .inc      (bp.upd_valid_i),
    .dec      (1'b0),
    .set_max  (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .q        (bp.branch_cnt_o)
  );

  otter_sat_counter #(.W(PERF_W)) u_mispred_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .inc      (mispredict),
    .dec      (1'b0),
    .set_max  (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .q        (bp.mispred_cnt_o)
  );
endmodule

// File: tb/tb_otter_branch_predictor.sv
// Scoreboard bench for otter_branch_predictor (XLEN=32, ENTRIES=16, CTR_W=2).
module tb_otter_branch_predictor;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic [31:0] redir;
  } obs_t;

  typedef struct packed {
    logic        rst;
    logic [31:0] pcf;
    logic        valid;
    logic [31:0] pc;
    logic        jump;
    logic        taken;
    logic [31:0] tgt;
    logic        ptaken;
    logic [31:0] ptgt;
    obs_t        exp;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nfail = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  otter_branch_predictor_if #(.XLEN(32), .PERF_W(32)) bp ();

  otter_branch_predictor #(
    .XLEN    (32),
    .ENTRIES (16),
    .CTR_W   (2),
    .PERF_W  (32)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bp    (bp)
  );

  function automatic step_t st(logic r, logic [31:0] pcf, logic v, logic [31:0] pc, logic j,
                               logic t, logic [31:0] tg, logic pt, logic [31:0] ptg,
                               logic eh, logic et, logic [31:0] etg, logic em,
                               logic [31:0] erd);
    step_t s;
    s.rst = r; s.pcf = pcf; s.valid = v; s.pc = pc; s.jump = j; s.taken = t;
    s.tgt = tg; s.ptaken = pt; s.ptgt = ptg;
    s.exp.hit = eh; s.exp.taken = et; s.exp.target = etg; s.exp.mis = em; s.exp.redir = erd;
    return s;
  endfunction

  // Idle cycle: no update, upd_pc_i=0 so the redirect reads 4
  function automatic step_t idle(logic [31:0] pcf, logic eh, logic et, logic [31:0] etg);
    return st(1'b0, pcf, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
              eh, et, etg, 1'b0, 32'h4);
  endfunction

  // Drive one cycle of stimulus just after the edge and queue its expectation
  task automatic apply(input step_t s);
    @(posedge clk);
    #1;
    rst                  = s.rst;
    bp.pcf_i             = s.pcf;
    bp.upd_valid_i       = s.valid;
    bp.upd_pc_i          = s.pc;
    bp.upd_is_jump_i     = s.jump;
    bp.upd_taken_i       = s.taken;
    bp.upd_target_i      = s.tgt;
    bp.upd_pred_taken_i  = s.ptaken;
    bp.upd_pred_target_i = s.ptgt;
    exp_q.push_back(s.exp);
  endtask

  task automatic test_reset();
    step_t s[$];
    obs_t  got, want;
    s.push_back(st(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h104, 1'b0, 32'h4));
    s.push_back(st(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h104, 1'b0, 32'h4));
    s.push_back(idle(32'h100, 1'b0, 1'b0, 32'h104));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      @(negedge clk);
      got  = {bp.pred_hit_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o,
              bp.redirect_pc_o};
      want = exp_q.pop_front();
      nvec++;
      if (got !== want) begin
        nfail++;
        $display("FAIL reset[%0d]: got hit=%b tk=%b tgt=%h mis=%b rd=%h, required hit=%b tk=%b tgt=%h mis=%b rd=%h",
                 i, got.hit, got.taken, got.target, got.mis, got.redir,
                 want.hit, want.taken, want.target, want.mis, want.redir);
      end
    end
    nvec++;
    if ({bp.branch_cnt_o, bp.mispred_cnt_o} !== 64'h0) begin
      nfail++;
      $display("FAIL reset_cnt: got %h/%h, required 0/0", bp.branch_cnt_o, bp.mispred_cnt_o);
    end
  endtask

  task automatic test_allocate();
    step_t s[$];
    obs_t  got, want;
    s.push_back(st(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104,
                   1'b0, 1'b0, 32'h104, 1'b1, 32'h80));
    s.push_back(idle(32'h100, 1'b1, 1'b1, 32'h80));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      @(negedge clk);
      got  = {bp.pred_hit_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o,
              bp.redirect_pc_o};
      want = exp_q.pop_front();
      nvec++;
      if (got !== want) begin
        nfail++;
        $display("FAIL alloc[%0d]: got hit=%b tk=%b tgt=%h mis=%b rd=%h, required hit=%b tk=%b tgt=%h mis=%b rd=%h",
                 i, got.hit, got.taken, got.target, got.mis, got.redir,
                 want.hit, want.taken, want.target, want.mis, want.redir);
      end
    end
    nvec++;
    if ({bp.branch_cnt_o, bp.mispred_cnt_o} !== {32'd1, 32'd1}) begin
      nfail++;
      $display("FAIL alloc_cnt: got %0d/%0d, required 1/1", bp.branch_cnt_o, bp.mispred_cnt_o);
    end
  endtask

  task automatic test_train();
    step_t s[$];
    obs_t  got, want;
    for (int k = 0; k < 3; k++) begin
      s.push_back(st(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80,
                     1'b1, 1'b1, 32'h80, 1'b0, 32'h104));
    end
    s.push_back(st(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80,
                   1'b1, 1'b1, 32'h80, 1'b1, 32'h104));
    s.push_back(idle(32'h100, 1'b1, 1'b1, 32'h80));
    s.push_back(st(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80,
                   1'b1, 1'b1, 32'h80, 1'b1, 32'h104));
    s.push_back(idle(32'h100, 1'b1, 1'b0, 32'h104));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      @(negedge clk);
      got  = {bp.pred_hit_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o,
              bp.redirect_pc_o};
      want = exp_q.pop_front();
      nvec++;
      if (got !== want) begin
        nfail++;
        $display("FAIL train[%0d]: got hit=%b tk=%b tgt=%h mis=%b rd=%h, required hit=%b tk=%b tgt=%h mis=%b rd=%h",
                 i, got.hit, got.taken, got.target, got.mis, got.redir,
                 want.hit, want.taken, want.target, want.mis, want.redir);
      end
    end
    nvec++;
    if ({bp.branch_cnt_o, bp.mispred_cnt_o} !== {32'd6, 32'd3}) begin
      nfail++;
      $display("FAIL train_cnt: got %0d/%0d, required 6/3", bp.branch_cnt_o, bp.mispred_cnt_o);
    end
  endtask

  // 0x200 shares index 0 with 0x100, so the JAL also evicts that entry
  task automatic test_jump();
    step_t s[$];
    obs_t  got, want;
    s.push_back(st(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204,
                   1'b0, 1'b0, 32'h204, 1'b1, 32'h400));
    s.push_back(idle(32'h200, 1'b1, 1'b1, 32'h400));
    s.push_back(st(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b1, 32'h404, 1'b1, 32'h400,
                   1'b1, 1'b1, 32'h400, 1'b1, 32'h404));
    s.push_back(idle(32'h200, 1'b1, 1'b1, 32'h404));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      @(negedge clk);
      got  = {bp.pred_hit_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o,
              bp.redirect_pc_o};
      want = exp_q.pop_front();
      nvec++;
      if (got !== want) begin
        nfail++;
        $display("FAIL jump[%0d]: got hit=%b tk=%b tgt=%h mis=%b rd=%h, required hit=%b tk=%b tgt=%h mis=%b rd=%h",
                 i, got.hit, got.taken, got.target, got.mis, got.redir,
                 want.hit, want.taken, want.target, want.mis, want.redir);
      end
    end
    nvec++;
    if ({bp.branch_cnt_o, bp.mispred_cnt_o} !== {32'd8, 32'd5}) begin
      nfail++;
      $display("FAIL jump_cnt: got %0d/%0d, required 8/5", bp.branch_cnt_o, bp.mispred_cnt_o);
    end
  endtask

  task automatic test_alias();
    step_t s[$];
    obs_t  got, want;
    s.push_back(st(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104,
                   1'b0, 1'b0, 32'h104, 1'b1, 32'h80));
    s.push_back(idle(32'h100, 1'b1, 1'b1, 32'h80));
    s.push_back(st(1'b0, 32'h140, 1'b1, 32'h140, 1'b0, 1'b1, 32'h180, 1'b0, 32'h144,
                   1'b0, 1'b0, 32'h144, 1'b1, 32'h180));
    s.push_back(idle(32'h100, 1'b0, 1'b0, 32'h104));
    s.push_back(idle(32'h140, 1'b1, 1'b1, 32'h180));
    // Not-taken miss at the aliased index must leave the resident entry alone
    s.push_back(st(1'b0, 32'h140, 1'b1, 32'h100, 1'b0, 1'b0, 32'h104, 1'b0, 32'h104,
                   1'b1, 1'b1, 32'h180, 1'b0, 32'h104));
    s.push_back(idle(32'h140, 1'b1, 1'b1, 32'h180));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      @(negedge clk);
      got  = {bp.pred_hit_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o,
              bp.redirect_pc_o};
      want = exp_q.pop_front();
      nvec++;
      if (got !== want) begin
        nfail++;
        $display("FAIL alias[%0d]: got hit=%b tk=%b tgt=%h mis=%b rd=%h, required hit=%b tk=%b tgt=%h mis=%b rd=%h",
                 i, got.hit, got.taken, got.target, got.mis, got.redir,
                 want.hit, want.taken, want.target, want.mis, want.redir);
      end
    end
    nvec++;
    if ({bp.branch_cnt_o, bp.mispred_cnt_o} !== {32'd11, 32'd7}) begin
      nfail++;
      $display("FAIL alias_cnt: got %0d/%0d, required 11/7", bp.branch_cnt_o, bp.mispred_cnt_o);
    end
  endtask

  task automatic test_reset_update();
    step_t s[$];
    obs_t  got, want;
    s.push_back(st(1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 32'h500, 1'b0, 32'h304,
                   1'b0, 1'b0, 32'h304, 1'b1, 32'h500));
    s.push_back(idle(32'h300, 1'b0, 1'b0, 32'h304));
    s.push_back(idle(32'h140, 1'b0, 1'b0, 32'h144));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      @(negedge clk);
      got  = {bp.pred_hit_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o,
              bp.redirect_pc_o};
      want = exp_q.pop_front();
      nvec++;
      if (got !== want) begin
        nfail++;
        $display("FAIL rst_upd[%0d]: got hit=%b tk=%b tgt=%h mis=%b rd=%h, required hit=%b tk=%b tgt=%h mis=%b rd=%h",
                 i, got.hit, got.taken, got.target, got.mis, got.redir,
                 want.hit, want.taken, want.target, want.mis, want.redir);
      end
    end
    nvec++;
    if ({bp.branch_cnt_o, bp.mispred_cnt_o} !== 64'h0) begin
      nfail++;
      $display("FAIL rst_upd_cnt: got %0d/%0d, required 0/0", bp.branch_cnt_o, bp.mispred_cnt_o);
    end
  endtask

  task automatic test_saturation();
    step_t s[$];
    obs_t  got, want;
    force dut.u_branch_cnt.cnt_q = 32'hFFFF_FFFE;
    force dut.u_mispred_cnt.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_branch_cnt.cnt_q;
    release dut.u_mispred_cnt.cnt_q;
    s.push_back(st(1'b0, 32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 32'h500, 1'b0, 32'h304,
                   1'b0, 1'b0, 32'h304, 1'b1, 32'h500));
    s.push_back(st(1'b0, 32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 32'h500, 1'b0, 32'h304,
                   1'b1, 1'b1, 32'h500, 1'b1, 32'h500));
    s.push_back(idle(32'h300, 1'b1, 1'b1, 32'h500));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      @(negedge clk);
      got  = {bp.pred_hit_o, bp.pred_taken_o, bp.pred_target_o, bp.mispredict_o,
              bp.redirect_pc_o};
      want = exp_q.pop_front();
      nvec++;
      if (got !== want) begin
        nfail++;
        $display("FAIL sat[%0d]: got hit=%b tk=%b tgt=%h mis=%b rd=%h, required hit=%b tk=%b tgt=%h mis=%b rd=%h",
                 i, got.hit, got.taken, got.target, got.mis, got.redir,
                 want.hit, want.taken, want.target, want.mis, want.redir);
      end
    end
    nvec++;
    if ({bp.branch_cnt_o, bp.mispred_cnt_o} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
      nfail++;
      $display("FAIL sat_cnt: got %h/%h, required ffffffff/ffffffff",
               bp.branch_cnt_o, bp.mispred_cnt_o);
    end
  endtask

  initial begin
    bp.pcf_i             = 32'h100;
    bp.upd_valid_i       = 1'b0;
    bp.upd_pc_i          = 32'h0;
    bp.upd_is_jump_i     = 1'b0;
    bp.upd_taken_i       = 1'b0;
    bp.upd_target_i      = 32'h0;
    bp.upd_pred_taken_i  = 1'b0;
    bp.upd_pred_target_i = 32'h0;
    test_reset();
    test_allocate();
    test_train();
    test_jump();
    test_alias();
    test_reset_update();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/otter_branch_predictor.md
Name: otter_branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage OTTER pipeline.
- Replaces the static "predict not-taken, resolve in Execute" policy.
- Fetch stage consumes the prediction in the same cycle as PCF. The Execute stage feeds back the resolved outcome; the block trains its table and flags mispredictions so the hazard unit flushes D/E.
- Implements a direct-mapped BTB with per-entry saturating counters and saturating performance counters.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB entry count; power of two, 2..256.
- CTR_W, 2, saturating counter width per entry; 1..4.
- PERF_W, 32, width of performance counters.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- pcf_i  in  XLEN  fetch PC (PCF)
- pred_hit_o  out  1  valid tag match for pcf_i
- pred_taken_o  out  1  predict taken (hit & counter MSB)
- pred_target_o  out  XLEN  predicted target; equals pcf_i+4 when pred_taken_o=0
- upd_valid_i  in  1  Execute holds a resolved control-flow instruction (not flushed)
- upd_pc_i  in  XLEN  PCE
- upd_is_jump_i  in  1  JAL/JALR (unconditional)
- upd_taken_i  in  1  actual outcome (PCSrcE)
- upd_target_i  in  XLEN  actual target (PCTargetE or JALR result)
- upd_pred_taken_i  in  1  prediction carried down the pipe with the instruction
- upd_pred_target_i  in  XLEN  predicted target carried down the pipe
- mispredict_o  out  1  redirect required
- redirect_pc_o  out  XLEN  correct next PC on mispredict
- branch_cnt_o  out  PERF_W  resolved control-flow instructions
- mispred_cnt_o  out  PERF_W  mispredictions

Behaviour:
- IDX_W = log2(ENTRIES); TAG_W = XLEN-IDX_W-2.
- index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Entry fields: valid, tag, target, counter.
- Lookup is combinational from the registered table, with zero added latency.
- A lookup and an update to the same index in the same cycle return the pre-update contents; there is no write-through bypass.
- Prediction taken iff: valid & tag match & (counter MSB = 1).
- Mispredict is combinational from the upd_* inputs and is gated by upd_valid_i:
  - mispredict_o = (upd_taken_i != upd_pred_taken_i) | (upd_taken_i & upd_target_i != upd_pred_target_i).
  - redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4.
  - When mispredict_o=0, redirect_pc_o is don't-care but must be stable (drive upd_pc_i+4).
- Training is registered at the CLK edge and applies only when upd_valid_i=1.
- Miss & taken: allocate (overwrite) the entry. valid=1, tag, target=upd_target_i, counter = jump ? all-ones : 1<<(CTR_W-1) (weakly taken).
- Miss & not-taken: no change to the table.
- Hit & taken: counter increments, saturating at all-ones; target is overwritten. A jump forces the counter to all-ones.
- Hit & not-taken: counter decrements, saturating at 0; target is kept; the entry stays valid.
- Aliasing: a tag mismatch at an occupied index is treated as a miss. This can evict the resident entry, by the rules above.
- Performance counters:
  - branch_cnt_o increments on every upd_valid_i.
  - mispred_cnt_o increments when mispredict_o=1.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous, dominates all other inputs):
  - All valid bits cleared; counters = (1<<(CTR_W-1))-1 (weakly not-taken); targets = 0.
  - Perf counters = 0.
  - In the reset cycle, pred_hit_o=0, pred_taken_o=0, pred_target_o=pcf_i+4.
  - mispredict_o follows its combinational equation. The pipeline flush on reset covers it.
- Reset mid-operation: an update presented in the same cycle as RESET is discarded.
- CTR_W=1 degenerates to a last-outcome predictor: allocation sets the counter to 1, and not-taken clears it.
- Stalls need no port: a stalled F re-presents the same pcf_i, and upd_valid_i must be driven 0 for bubbles and flushed instructions.

Decomposition:
- Package otter_bp_pkg holds:
  - the bp_entry_t packed struct (valid, tag, target, counter);
  - bp_index/bp_tag functions parametrised by IDX_W;
  - localparam helpers for the counter reset and weak-taken values.
- Sub-module otter_sat_counter (parameter W): inc/dec/set_max/load inputs, saturating. It is instantiated once per perf counter. The per-entry counters use the same next-value function from the package.

Test Plan:
- Reset, then pcf_i=0x100 -> pred_hit_o=0, pred_taken_o=0, pred_target_o=0x104. Both perf counters read 0.
- Update pc=0x100, taken, target=0x80, pred_taken=0 -> same-cycle mispredict_o=1, redirect_pc_o=0x80. Next cycle, lookup 0x100 -> hit, taken, target 0x80. mispred_cnt_o=1.
- Train 0x100 with taken ×3, then not-taken ×1 (CTR_W=2) -> still predicts taken (counter 2). A second not-taken -> predicts not-taken, target output 0x104.
- JAL at 0x200 -> target 0x400 on a miss, allocated with counter 3. Lookup predicts taken immediately after. A correct prediction with a wrong target 0x404 -> mispredict_o=1, redirect 0x404.
- Alias with ENTRIES=16: 0x100 and 0x140 share index 0. Allocate 0x100, then a taken update at 0x140 -> lookup 0x100 misses, 0x140 hits. Same-cycle lookup of 0x140 during its allocation returns a miss.
- Assert RESET concurrently with upd_valid_i=1 (taken, pc=0x300) -> no allocation, counters stay 0. Preload perf counters near max (force) -> they saturate at 0xFFFFFFFF.
